dmem_arbiter: RTL and testbench

Two-port arbiter that shares the CPU's single data RAM between the CPU load/store path and a secondary master (DMA/program loader). It sits between the `cpu` memory outputs and the 12-bit-address data RAM. It grants one access per cycle, with CPU priority and bounded starvation for the secondary port. It also routes the RAM's one-cycle-latency read data back to the port that issued the read.

---
 rtl/dmem_arbiter.sv | 88 ++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU port and a secondary (DMA/loader) port.
// CPU has priority; the D port is forced ahead after STARVE_LIMIT lost cycles. Read data is routed back by per-cycle owner flags.
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_wr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic       c_pend;
  logic       d_pend;
  logic       force_d;

  assign force_d = d_req && (starve_cnt == LIMIT);

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (force_d)    d_gnt = 1'b1;
      else if (c_req) c_gnt = 1'b1;
      else if (d_req) d_gnt = 1'b1;
    end
  end

  assign ram_en = c_gnt | d_gnt;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (c_gnt) begin
      ram_we    = c_wr;
      ram_addr  = c_addr;
      ram_wdata = c_wdata;
    end else if (d_gnt) begin
      ram_we    = d_wr;
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end
  end

  // Counter only advances on cycles the CPU actually won over a waiting D request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      c_pend     <= 1'b0;
      d_pend     <= 1'b0;
    end else begin
      if (!d_req || d_gnt)
        starve_cnt <= '0;
      else if (c_gnt && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + 8'd1;
      c_pend <= c_gnt & ~c_wr;
      d_pend <= d_gnt & ~d_wr;
    end
  end

  assign c_rvalid = c_pend;
  assign d_rvalid = d_pend;
  assign c_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a request-level model of priority, starvation and read routing.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_wr, d_req, d_wr;
  logic [11:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem [0:4095];

  int checks = 0;
  int passes = 0;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM environment with a bench-only load port used while the DUT is idle.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    c_req = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    c_req = 1'b1; d_req = 1'b1;
    #1;
    checks++; if (c_gnt !== 1'b0) $display("FAIL reset_c_gnt got %b want 0", c_gnt); else passes++;
    checks++; if (d_gnt !== 1'b0) $display("FAIL reset_d_gnt got %b want 0", d_gnt); else passes++;
    checks++; if (ram_en !== 1'b0) $display("FAIL reset_ram_en got %b want 0", ram_en); else passes++;
    checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b%b want 00", c_rvalid, d_rvalid); else passes++;
    reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_cpu_read();
    preload(12'h010, 32'hDEADBEEF);
    c_req = 1'b1; c_wr = 1'b0; c_addr = 12'h010;
    @(negedge clk);
    checks++; if (c_gnt !== 1'b1) $display("FAIL cpu_read_gnt got %b want 1", c_gnt); else passes++;
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0) $display("FAIL cpu_read_en_we got %b%b want 10", ram_en, ram_we); else passes++;
    checks++; if (ram_addr !== 12'h010) $display("FAIL cpu_read_addr got %h want 010", ram_addr); else passes++;
    tick();
    idle();
    @(negedge clk);
    checks++; if (c_rvalid !== 1'b1) $display("FAIL cpu_read_rvalid got %b want 1", c_rvalid); else passes++;
    checks++; if (c_rdata !== 32'hDEADBEEF) $display("FAIL cpu_read_rdata got %h want deadbeef", c_rdata); else passes++;
    checks++; if (d_rvalid !== 1'b0) $display("FAIL cpu_read_d_rvalid got %b want 0", d_rvalid); else passes++;
    tick();
  endtask

  task automatic test_d_write_c_read();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 12'h020; d_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) $display("FAIL dwr_gnt got c%b d%b want c0 d1", c_gnt, d_gnt); else passes++;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h020 || ram_wdata !== 32'h12345678)
      $display("FAIL dwr_ram got we%b %h %h want we1 020 12345678", ram_we, ram_addr, ram_wdata); else passes++;
    tick();
    idle();
    c_req = 1'b1; c_addr = 12'h020;
    @(negedge clk);
    checks++; if (c_gnt !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL dwr_cread_gnt got gnt%b drv%b want 1 0", c_gnt, d_rvalid); else passes++;
    tick();
    idle();
    @(negedge clk);
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h12345678) $display("FAIL dwr_cread_data got %b %h want 1 12345678", c_rvalid, c_rdata); else passes++;
    checks++; if (d_rvalid !== 1'b0) $display("FAIL dwr_d_rvalid got %b want 0", d_rvalid); else passes++;
    tick();
  endtask

  task automatic test_contention();
    c_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (d_gnt !== (i % 5 == 4) || c_gnt !== (i % 5 != 4))
        $display("FAIL contention_cycle%0d got c%b d%b want c%b d%b", i, c_gnt, d_gnt, i % 5 != 4, i % 5 == 4);
      else passes++;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_withdrawal();
    c_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_req = (i != 2);
      @(negedge clk);
      checks++;
      if (d_gnt !== (i == 7) || c_gnt !== (i != 7))
        $display("FAIL withdrawal_cycle%0d got c%b d%b want c%b d%b", i, c_gnt, d_gnt, i != 7, i == 7);
      else passes++;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_interleave();
    preload(12'h001, 32'h0000000A);
    preload(12'h002, 32'h0000000B);
    c_req = 1'b1; c_addr = 12'h001;
    tick();
    idle();
    d_req = 1'b1; d_addr = 12'h002;
    @(negedge clk);
    checks++; if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0 || c_rdata !== 32'hA)
      $display("FAIL interleave_n1 got crv%b drv%b %h want 1 0 0000000a", c_rvalid, d_rvalid, c_rdata); else passes++;
    checks++; if (d_gnt !== 1'b1) $display("FAIL interleave_d_gnt got %b want 1", d_gnt); else passes++;
    tick();
    idle();
    @(negedge clk);
    checks++; if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || d_rdata !== 32'hB)
      $display("FAIL interleave_n2 got crv%b drv%b %h want 0 1 0000000b", c_rvalid, d_rvalid, d_rdata); else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    c_req = 1'b1; c_addr = 12'h010; d_req = 1'b1; d_addr = 12'h002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (c_gnt !== 1'b1) $display("FAIL rstmid_pre_cycle%0d c_gnt got %b want 1", i, c_gnt); else passes++;
      if (i < 3) tick();
    end
    checks++; if (c_rvalid !== 1'b1) $display("FAIL rstmid_pre_rvalid got %b want 1", c_rvalid); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || c_rvalid !== 1'b0 || d_rvalid !== 1'b0)
      $display("FAIL rstmid_flags got gnt%b%b rv%b%b want 0000", c_gnt, d_gnt, c_rvalid, d_rvalid); else passes++;
    checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0)
      $display("FAIL rstmid_ram got %b %b %h %h want all 0", ram_en, ram_we, ram_addr, ram_wdata); else passes++;
    tick();
    checks++; if (c_rvalid !== 1'b0) $display("FAIL rstmid_held_rvalid got %b want 0", c_rvalid); else passes++;
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (d_gnt !== (i == 4) || c_gnt !== (i != 4))
        $display("FAIL rstmid_post_cycle%0d got c%b d%b want c%b d%b", i, c_gnt, d_gnt, i != 4, i == 4);
      else passes++;
      if (i == 0) begin
        checks++; if (c_rvalid !== 1'b0) $display("FAIL rstmid_post_rvalid got %b want 0", c_rvalid); else passes++;
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic new_c();
    c_req   = ($urandom_range(0, 3) != 0);
    c_wr    = 1'($urandom_range(0, 1));
    c_addr  = 12'($urandom_range(0, 15));
    c_wdata = $urandom;
  endtask

  task automatic new_d();
    d_req   = ($urandom_range(0, 1) != 0);
    d_wr    = 1'($urandom_range(0, 1));
    d_addr  = 12'($urandom_range(0, 15));
    d_wdata = $urandom;
  endtask

  // Model: D's consecutive lost-while-requesting cycles decide forcing; a shadow memory supplies read data.
  task automatic test_random();
    logic [31:0] shadow [0:15];
    int          d_wait;
    logic        ec, ed, frc, pc, pd, npc, npd, e_we;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, pdata, ndata;
    for (int i = 0; i < 16; i++) begin
      shadow[i] = $urandom;
      preload(12'(i), shadow[i]);
    end
    d_wait = 0; pc = 1'b0; pd = 1'b0; pdata = '0;
    new_c(); new_d();
    for (int cyc = 0; cyc < 400; cyc++) begin
      frc = d_req && (d_wait == LIMIT);
      ed  = frc || (d_req && !c_req);
      ec  = c_req && !frc;
      e_we = 1'b0; e_addr = '0; e_wdata = '0;
      if (ec)      begin e_we = c_wr; e_addr = c_addr; e_wdata = c_wdata; end
      else if (ed) begin e_we = d_wr; e_addr = d_addr; e_wdata = d_wdata; end
      @(negedge clk);
      checks++; if (c_gnt !== ec || d_gnt !== ed) $display("FAIL rand_gnt cyc%0d got c%b d%b want c%b d%b", cyc, c_gnt, d_gnt, ec, ed); else passes++;
      checks++; if (ram_en !== (ec | ed) || ram_we !== e_we) $display("FAIL rand_en_we cyc%0d got %b%b want %b%b", cyc, ram_en, ram_we, ec | ed, e_we); else passes++;
      checks++; if (ram_addr !== e_addr || ram_wdata !== e_wdata) $display("FAIL rand_ram cyc%0d got %h %h want %h %h", cyc, ram_addr, ram_wdata, e_addr, e_wdata); else passes++;
      checks++; if (c_rvalid !== pc || d_rvalid !== pd) $display("FAIL rand_rvalid cyc%0d got c%b d%b want c%b d%b", cyc, c_rvalid, d_rvalid, pc, pd); else passes++;
      if (pc) begin
        checks++; if (c_rdata !== pdata) $display("FAIL rand_c_rdata cyc%0d got %h want %h", cyc, c_rdata, pdata); else passes++;
      end
      if (pd) begin
        checks++; if (d_rdata !== pdata) $display("FAIL rand_d_rdata cyc%0d got %h want %h", cyc, d_rdata, pdata); else passes++;
      end
      npc = 1'b0; npd = 1'b0; ndata = '0;
      if (ec) begin
        if (c_wr) shadow[c_addr[3:0]] = c_wdata;
        else begin npc = 1'b1; ndata = shadow[c_addr[3:0]]; end
      end else if (ed) begin
        if (d_wr) shadow[d_addr[3:0]] = d_wdata;
        else begin npd = 1'b1; ndata = shadow[d_addr[3:0]]; end
      end
      if (!d_req || ed) d_wait = 0;
      else if (ec && d_wait < LIMIT) d_wait++;
      pc = npc; pd = npd; pdata = ndata;
      tick();
      if (ec || !c_req) new_c();
      if (ed || !d_req) new_d();
    end
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    idle();
    tick();
    test_reset();
    test_cpu_read();
    test_d_write_c_read();
    test_contention();
    test_withdrawal();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
